// File: rtl/demux_1to16_buf.sv
// Buffered 1-to-16 demultiplexer: steers one N-bit word into one of 16 single-entry
// valid/ready output slots. Define DEMUX_BROADCAST_EN to add the bcast port (load all slots).
module demux_1to16_buf #(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    X,
  input  logic [3:0]      C,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [16*N-1:0] R,
  output logic [15:0]     R_valid,
  input  logic [15:0]     R_ready,
`ifdef DEMUX_BROADCAST_EN
  input  logic            bcast,
`endif
  output logic [4:0]      count
);

  logic [N-1:0] slot_q [16];
  logic [15:0]  valid_q;
  logic [4:0]   count_q;

  logic [15:0]  slot_free;
  logic [15:0]  sel_mask;
  logic [15:0]  load_mask;
  logic [15:0]  consume_mask;
  logic [15:0]  valid_next;
  logic [4:0]   count_next;
  logic         bcast_req;
  logic         accept;

`ifdef DEMUX_BROADCAST_EN
  assign bcast_req = in_valid & bcast;
`else
  assign bcast_req = 1'b0;
`endif

  // A slot can take a new word if it is empty or is being drained on this same edge.
  assign slot_free    = ~valid_q | R_ready;
  assign sel_mask     = 16'b1 << C;
  assign consume_mask = valid_q & R_ready;

  assign in_ready = rst_n & (bcast_req ? (&slot_free) : slot_free[C]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    load_mask  = '0;
    count_next = '0;
    if (accept) begin
      load_mask = bcast_req ? 16'hFFFF : sel_mask;
    end
    // Consume clears first, then a load re-sets: same-slot drain-and-refill stays full.
    valid_next = (valid_q & ~consume_mask) | load_mask;
    for (int k = 0; k < 16; k++) begin
      count_next = count_next + 5'(valid_next[k]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_next;
      count_q <= count_next;
    end
  end

  // NOTE: the slot storage is cleared on reset on purpose, because R must read
  // zero after reset; plain buffer storage would normally be left unreset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (load_mask[k]) begin
          slot_q[k] <= X;
        end
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign R[g*N +: N] = slot_q[g];
  end

  assign R_valid = valid_q;
  assign count   = count_q;

endmodule

// File: tb/tb_demux_1to16_buf.sv
// Randomized plus directed bench for demux_1to16_buf against an array-based slot model.
// Build with DEMUX_BROADCAST_EN defined to exercise the broadcast feature as well.
module tb_demux_1to16_buf;

  localparam int N = 32;
`ifdef DEMUX_BROADCAST_EN
  localparam bit BCAST_ON = 1'b1;
`else
  localparam bit BCAST_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    X;
  logic [3:0]      C;
  logic            in_valid;
  logic            in_ready;
  logic [16*N-1:0] R;
  logic [15:0]     R_valid;
  logic [15:0]     R_ready;
  logic [4:0]      count;
  logic            bcast_in;

  always #5 clk = ~clk;

  demux_1to16_buf #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .X        (X),
    .C        (C),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .R        (R),
    .R_valid  (R_valid),
    .R_ready  (R_ready),
`ifdef DEMUX_BROADCAST_EN
    .bcast    (bcast_in),
`endif
    .count    (count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one entry per slot, a flag and the word it holds.
  bit           m_full [16];
  logic [N-1:0] m_word [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready();
    if (!rst_n) return 1'b0;
    if (BCAST_ON && in_valid && bcast_in) begin
      for (int k = 0; k < 16; k++)
        if (m_full[k] && !R_ready[k]) return 1'b0;
      return 1'b1;
    end
    return !m_full[C] || R_ready[C];
  endfunction

  task automatic check_outputs();
    logic [15:0] exp_valid = '0;
    int          exp_count = 0;
    for (int k = 0; k < 16; k++) begin
      exp_valid[k] = m_full[k];
      exp_count += int'(m_full[k]);
    end
    check("R_valid", 64'(R_valid), 64'(exp_valid));
    check("count", 64'(count), 64'(exp_count));
    for (int k = 0; k < 16; k++)
      check($sformatf("slot%0d", k), 64'(R[k*N +: N]), 64'(m_word[k]));
  endtask

  task automatic drive(input logic [N-1:0] x, input logic [3:0] c, input logic v,
                       input logic [15:0] rr, input logic b);
    X = x; C = c; in_valid = v; R_ready = rr; bcast_in = b;
  endtask

  // One clock: check in_ready mid-cycle, advance the model at the edge, check outputs after.
  task automatic step();
    bit rdy;
    @(negedge clk);
    rdy = model_ready();
    check("in_ready", 64'(in_ready), 64'(rdy));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        m_full[k] = 1'b0;
        m_word[k] = '0;
      end
    end else begin
      for (int k = 0; k < 16; k++)
        if (R_ready[k]) m_full[k] = 1'b0;
      if (in_valid && rdy) begin
        if (BCAST_ON && bcast_in) begin
          for (int k = 0; k < 16; k++) begin
            m_full[k] = 1'b1;
            m_word[k] = X;
          end
        end else begin
          m_full[C] = 1'b1;
          m_word[C] = X;
        end
      end
    end
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    drive('0, '0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      m_full[k] = 1'b0;
      m_word[k] = '0;
    end

    // 1: reset for two cycles, then one transfer to slot 5
    step();
    step();
    check("t1_reset_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    drive(32'hDEADBEEF, 4'd5, 1'b1, 16'h0, 1'b0);
    step();
    check("t1_rvalid", 64'(R_valid), 64'h0020);
    check("t1_slot5", 64'(R[5*N +: N]), 64'hDEADBEEF);
    check("t1_count", 64'(count), 64'd1);

    // 2: back-pressure on slot 5, then released by a same-cycle consume
    drive(32'h1, 4'd5, 1'b1, 16'h0, 1'b0);
    #1;
    check("t2_blocked", 64'(in_ready), 64'd0);
    step();
    check("t2_slot5_held", 64'(R[5*N +: N]), 64'hDEADBEEF);
    drive(32'h1, 4'd5, 1'b1, 16'h0020, 1'b0);
    #1;
    check("t2_released", 64'(in_ready), 64'd1);
    step();
    check("t2_slot5_new", 64'(R[5*N +: N]), 64'h1);
    check("t2_count", 64'(count), 64'd1);

    // 3: drain, then fill all 16 slots with their own index
    drive('0, '0, 1'b0, 16'hFFFF, 1'b0);
    step();
    for (int k = 0; k < 16; k++) begin
      drive(N'(k), 4'(k), 1'b1, 16'h0, 1'b0);
      step();
    end
    check("t3_count", 64'(count), 64'd16);
    check("t3_rvalid", 64'(R_valid), 64'hFFFF);
    drive(32'h77, 4'd9, 1'b1, 16'h0, 1'b0);
    step();

    // 4: drain everything while refilling slot 3
    drive(32'hA5, 4'd3, 1'b1, 16'hFFFF, 1'b0);
    step();
    check("t4_rvalid", 64'(R_valid), 64'h0008);
    check("t4_count", 64'(count), 64'd1);
    check("t4_slot3", 64'(R[3*N +: N]), 64'hA5);

    // 5: reset with slots 0..7 full and a request pending
    drive('0, '0, 1'b0, 16'hFFFF, 1'b0);
    step();
    for (int k = 0; k < 8; k++) begin
      drive(32'h100 + N'(k), 4'(k), 1'b1, 16'h0, 1'b0);
      step();
    end
    rst_n = 1'b0;
    drive(32'hCAFE, 4'd12, 1'b1, 16'h0, 1'b0);
    step();
    rst_n = 1'b1;
    check("t5_rvalid", 64'(R_valid), 64'h0);
    check("t5_count", 64'(count), 64'd0);

`ifdef DEMUX_BROADCAST_EN
    // 6: broadcast into empty block, then blocked by a stuck slot
    drive(32'h55AA55AA, 4'd0, 1'b1, 16'h0, 1'b1);
    step();
    check("t6_rvalid", 64'(R_valid), 64'hFFFF);
    check("t6_count", 64'(count), 64'd16);
    drive('0, '0, 1'b0, 16'hFFFF, 1'b0);
    step();
    drive(32'h2, 4'd2, 1'b1, 16'h0, 1'b0);
    step();
    drive(32'h9, 4'd7, 1'b1, 16'h0, 1'b1);
    #1;
    check("t6_blocked", 64'(in_ready), 64'd0);
    step();
`endif

    // Random traffic: sparse consumers, occasional reset and broadcast requests
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      drive($urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
            16'($urandom & $urandom), $urandom_range(0, 15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1to16_buf.md
Name: demux_1to16_buf

Overview:
- Buffered 1-to-16 demultiplexer; the distribution-side counterpart of the ALU's 16-to-1 select path.
- Takes one N-bit word plus a 4-bit destination select and steers it into one of 16 single-entry output slots.
- Each slot holds its word until its consumer takes it, using a per-slot valid/ready handshake.
- Sits between the ALU result bus and up to 16 downstream consumers (register write ports, flag/status sinks).

Parameters:
N, 32, width of the data word and of each output slot.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
X  input  N  input data word.
C  input  4  destination slot select; C=k targets slot k (0..15).
in_valid  input  1  X/C valid this cycle.
in_ready  output  1  block can accept X/C this cycle.
R  output  16*N  slot data, packed; slot k occupies R[k*N +: N].
R_valid  output  16  bit k set when slot k holds an unconsumed word.
R_ready  input  16  bit k set when consumer k takes slot k this cycle.
count  output  5  number of occupied slots (0..16).
bcast  input  1  broadcast request; present only when DEMUX_BROADCAST_EN is defined.

Behaviour:
- Reset: sampled on the rising edge while rst_n=0.
  - R_valid=0, all R slots=0, count=0.
  - in_ready is forced to 0 while rst_n=0.
  - Reset mid-operation discards every held word; no handshake completes in a reset cycle.
- in_ready (combinational) = rst_n & (~R_valid[C] | R_ready[C]). It depends only on the targeted slot.
- Accept: a transfer occurs when in_valid & in_ready.
  - On that edge, slot C data is set to X and R_valid[C] is set to 1.
  - Latency is 1 cycle: the data is visible on R/R_valid the cycle after acceptance.
- Consume: when R_valid[k] & R_ready[k] on an edge, R_valid[k] is cleared.
  - Slot data is not cleared; it retains its last value.
- Simultaneous consume and accept on the same slot: R_valid[k] stays 1 and slot data is replaced by the new X. Full throughput of 1 word/cycle is sustained on a single slot.
- Simultaneous activity on different slots is independent: one accept plus any number of consumes per cycle.
- R_ready[k] is ignored while R_valid[k]=0.
- Slot data is stable while R_valid[k]=1 and it has not been consumed.
- in_valid=0: C and X are don't-care and no state changes.
- Back-pressure: if slot C is full and not being consumed, in_ready=0. The producer must hold X/C until acceptance; no other slot is affected.
- count is registered.
  - Next count = count + accepted_new_fill − consumed_without_refill.
  - A same-slot consume-and-refill leaves count unchanged.
  - count=16 when all slots are full; it never wraps.

Optional Feature:
- Macro: DEMUX_BROADCAST_EN.
- Defined:
  - The bcast port exists.
  - With in_valid & bcast, C is ignored and in_ready = rst_n & AND over k of (~R_valid[k] | R_ready[k]).
  - On acceptance, all 16 slots load X, R_valid becomes 16'hFFFF and count becomes 16.
  - With bcast=0 the block behaves as in the base mode.
- Not defined: the bcast port is absent and the block has only base behaviour.

Test Plan:
1. Reset and single transfer:
   - Stimulus: reset held for 2 cycles, then X=32'hDEADBEEF, C=4'd5, in_valid=1 for 1 cycle, R_ready=0.
   - Required: next cycle R_valid=16'h0020, R[5*32 +: 32]=32'hDEADBEEF, count=1.
2. Back-pressure:
   - Stimulus: slot 5 full with R_ready[5]=0; present X=32'h1, C=5.
   - Required: in_ready=0, slot 5 still 32'hDEADBEEF.
   - Then R_ready[5]=1 in the same cycle: in_ready=1, and next cycle slot 5=32'h1, R_valid[5]=1, count unchanged.
3. Fill all slots:
   - Stimulus: X=k, C=k for k=0..15 on consecutive cycles.
   - Required: count reaches 16, R_valid=16'hFFFF, every slot k equals k.
   - Then any C gives in_ready=0 while R_ready=0.
4. Parallel drain during input:
   - Stimulus: all slots full, R_ready=16'hFFFF for one cycle, with accept X=32'hA5, C=3.
   - Required: next cycle R_valid=16'h0008, count=1, slot 3=32'hA5.
5. Reset mid-operation:
   - Stimulus: slots 0..7 full; assert rst_n=0 for 1 cycle while in_valid=1.
   - Required: R_valid=0, count=0, all slots 0; no transfer accepted during reset.
6. Broadcast (DEMUX_BROADCAST_EN defined):
   - Stimulus: all slots empty; bcast=1, X=32'h55AA55AA, in_valid=1.
   - Required: next cycle R_valid=16'hFFFF, all slots 32'h55AA55AA, count=16.
   - With slot 2 full and R_ready[2]=0, a broadcast request sees in_ready=0.
